// File: rtl/ctx_wrq_fifo.sv
// ctx_wrq_fifo: posted write queue between context capture and the memory bus arbiter.
// One request is presented at a time and held until the arbiter accepts it.
module ctx_wrq_fifo #(
   parameter int DEPTH = 8
) (
   input  logic        clkin,
   input  logic        reset,
   input  logic        CTX_WRQ,
   input  logic [23:0] CTX_ADDR,
   input  logic [15:0] CTX_DATA,
   input  logic        CTX_WORD,
   input  logic        FLUSH,
   output logic        MEM_WRQ,
   input  logic        MEM_RDY,
   output logic [23:0] MEM_ADDR,
   output logic [15:0] MEM_DATA,
   output logic        MEM_WORD,
   output logic        BUSY,
   output logic        OVF,
   output logic [7:0]  OVF_CNT
);
   localparam int AW = $clog2(DEPTH);
   typedef enum logic {IDLE, ISSUE} state_t;
   state_t state, state_nxt;
   logic [23:0] q_addr [DEPTH];
   logic [15:0] q_data [DEPTH];
   logic        q_word [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0] count;
   logic full, push, pop, drop;
   assign full = count == (AW+1)'(DEPTH);
   // a full queue drops the request even if the head leaves this same cycle
   assign push = CTX_WRQ & ~FLUSH & ~full;
   assign drop = CTX_WRQ & ~FLUSH & full;
   assign pop  = ~FLUSH & (state == IDLE) & (count != '0);
   assign BUSY = (count != '0) | (state == ISSUE);
   always_comb begin
      state_nxt = state;
      state_nxt = (state == IDLE) ? (pop ? ISSUE : IDLE) : (MEM_RDY ? IDLE : ISSUE);
   end
   always_ff @(posedge clkin or posedge reset) begin
      if (reset) state <= IDLE;
      else state <= state_nxt;
   end
   always_ff @(posedge clkin) begin
      if (push) begin
         q_addr[wr_ptr] <= CTX_ADDR;
         q_data[wr_ptr] <= CTX_DATA;
         q_word[wr_ptr] <= CTX_WORD;
      end
   end
   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (FLUSH) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end
   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         OVF     <= 1'b0;
         OVF_CNT <= '0;
      end else if (FLUSH) begin
         OVF     <= 1'b0;
         OVF_CNT <= '0;
      end else if (drop) begin
         OVF     <= 1'b1;
         OVF_CNT <= (OVF_CNT == 8'hFF) ? OVF_CNT : OVF_CNT + 8'd1;
      end
   end
   always_ff @(posedge clkin or posedge reset) begin
      if (reset) begin
         MEM_WRQ  <= 1'b0;
         MEM_ADDR <= '0;
         MEM_DATA <= '0;
         MEM_WORD <= 1'b0;
      end else begin
         MEM_WRQ <= state_nxt == ISSUE;
         if (pop) begin
            MEM_ADDR <= q_addr[rd_ptr];
            MEM_DATA <= q_data[rd_ptr];
            MEM_WORD <= q_word[rd_ptr];
         end
      end
   end
endmodule

// File: tb/tb_ctx_wrq_fifo.sv
// tb_ctx_wrq_fifo: vector table plus scoreboard-checked sequences for ctx_wrq_fifo.
module tb_ctx_wrq_fifo;
   logic        clkin = 1'b0;
   logic        reset = 1'b1;
   logic        CTX_WRQ = 1'b0;
   logic [23:0] CTX_ADDR = '0;
   logic [15:0] CTX_DATA = '0;
   logic        CTX_WORD = 1'b0;
   logic        FLUSH = 1'b0;
   logic        MEM_WRQ;
   logic        MEM_RDY = 1'b1;
   logic [23:0] MEM_ADDR;
   logic [15:0] MEM_DATA;
   logic        MEM_WORD;
   logic        BUSY;
   logic        OVF;
   logic [7:0]  OVF_CNT;
   int total = 0;
   int bad = 0;

   ctx_wrq_fifo #(.DEPTH(8)) dut (
      .clkin(clkin), .reset(reset), .CTX_WRQ(CTX_WRQ), .CTX_ADDR(CTX_ADDR),
      .CTX_DATA(CTX_DATA), .CTX_WORD(CTX_WORD), .FLUSH(FLUSH), .MEM_WRQ(MEM_WRQ),
      .MEM_RDY(MEM_RDY), .MEM_ADDR(MEM_ADDR), .MEM_DATA(MEM_DATA), .MEM_WORD(MEM_WORD),
      .BUSY(BUSY), .OVF(OVF), .OVF_CNT(OVF_CNT)
   );

   always #5 clkin = ~clkin;

   typedef struct {
      logic [23:0] addr;
      logic [15:0] data;
      logic        word;
   } ent_t;
   ent_t sb[$];

   typedef struct {
      logic        wrq;
      logic [23:0] addr;
      logic [15:0] data;
      logic        word;
      logic        flush;
      logic        rdy;
      logic        e_wrq;
      logic        e_busy;
      logic        e_ovf;
      logic [7:0]  e_cnt;
   } vec_t;
   vec_t tbl [11];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clkin);
      #1;
   endtask

   task automatic push(input logic [23:0] a, input logic [15:0] d, input logic w, input bit issued);
      CTX_WRQ = 1'b1;
      CTX_ADDR = a;
      CTX_DATA = d;
      CTX_WORD = w;
      if (issued) sb.push_back('{a, d, w});
      tick();
      CTX_WRQ = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 200 && sb.size() > 0; i++) tick();
      chk("drain_left", sb.size(), 0);
      tick();
      tick();
   endtask

   // accepted transfers are checked against the push-order scoreboard
   always @(negedge clkin) begin
      ent_t e;
      if (!reset && MEM_WRQ && MEM_RDY) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr %0h expected none", MEM_ADDR);
         end else begin
            e = sb.pop_front();
            chk("wr_addr", MEM_ADDR, e.addr);
            chk("wr_data", MEM_DATA, e.data);
            chk("wr_word", MEM_WORD, e.word);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{1, 24'hF50123, 16'h00AB, 0, 0, 1, 0, 1, 0, 0};
      tbl[1]  = '{0, 24'h0, 16'h0, 0, 0, 1, 1, 1, 0, 0};
      tbl[2]  = '{0, 24'h0, 16'h0, 0, 0, 1, 0, 0, 0, 0};
      tbl[3]  = '{1, 24'h123456, 16'hBEEF, 1, 0, 0, 0, 1, 0, 0};
      tbl[4]  = '{1, 24'h000001, 16'h0001, 0, 0, 0, 1, 1, 0, 0};
      tbl[5]  = '{0, 24'h0, 16'h0, 0, 0, 0, 1, 1, 0, 0};
      tbl[6]  = '{0, 24'h0, 16'h0, 0, 0, 1, 0, 1, 0, 0};
      tbl[7]  = '{0, 24'h0, 16'h0, 0, 0, 1, 1, 1, 0, 0};
      tbl[8]  = '{0, 24'h0, 16'h0, 0, 0, 1, 0, 0, 0, 0};
      tbl[9]  = '{1, 24'h777777, 16'h7777, 1, 1, 1, 0, 0, 0, 0};
      tbl[10] = '{0, 24'h0, 16'h0, 0, 0, 1, 0, 0, 0, 0};
      #3;
      chk("rst_wrq", MEM_WRQ, 0);
      chk("rst_addr", MEM_ADDR, 0);
      chk("rst_data", MEM_DATA, 0);
      chk("rst_word", MEM_WORD, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_ovf", OVF, 0);
      chk("rst_cnt", OVF_CNT, 0);
      tick();
      tick();
      reset = 1'b0;
      for (int r = 0; r < 11; r++) begin
         CTX_WRQ = tbl[r].wrq;
         CTX_ADDR = tbl[r].addr;
         CTX_DATA = tbl[r].data;
         CTX_WORD = tbl[r].word;
         FLUSH = tbl[r].flush;
         MEM_RDY = tbl[r].rdy;
         if (tbl[r].wrq && !tbl[r].flush) sb.push_back('{tbl[r].addr, tbl[r].data, tbl[r].word});
         tick();
         chk($sformatf("vec%0d_wrq", r), MEM_WRQ, tbl[r].e_wrq);
         chk($sformatf("vec%0d_busy", r), BUSY, tbl[r].e_busy);
         chk($sformatf("vec%0d_ovf", r), OVF, tbl[r].e_ovf);
         chk($sformatf("vec%0d_cnt", r), OVF_CNT, tbl[r].e_cnt);
      end
      CTX_WRQ = 1'b0;
      FLUSH = 1'b0;
      chk("vec_sb_empty", sb.size(), 0);
      // ten pushes into a stalled arbiter: one in flight, eight queued, one dropped
      MEM_RDY = 1'b0;
      for (int i = 1; i <= 10; i++) push(24'hA00000 + 24'(i), 16'(i * 3), i[0], i <= 9);
      tick();
      chk("ovf_flag", OVF, 1);
      chk("ovf_cnt1", OVF_CNT, 1);
      chk("ovf_inflight_wrq", MEM_WRQ, 1);
      chk("ovf_inflight_addr", MEM_ADDR, 24'hA00001);
      MEM_RDY = 1'b1;
      drain();
      chk("ovf_sticky", OVF, 1);
      chk("ovf_idle_busy", BUSY, 0);
      FLUSH = 1'b1;
      tick();
      FLUSH = 1'b0;
      chk("flush_clr_ovf", OVF, 0);
      // saturation then flush with an entry still in flight
      MEM_RDY = 1'b0;
      for (int i = 0; i < 300; i++) push(24'hB00000 + 24'(i), 16'(i), 1'b1, i == 0);
      chk("sat_cnt", OVF_CNT, 8'hFF);
      chk("sat_ovf", OVF, 1);
      FLUSH = 1'b1;
      tick();
      FLUSH = 1'b0;
      chk("sat_flush_ovf", OVF, 0);
      chk("sat_flush_cnt", OVF_CNT, 0);
      chk("sat_flush_busy", BUSY, 1);
      chk("sat_flush_wrq", MEM_WRQ, 1);
      MEM_RDY = 1'b1;
      tick();
      chk("sat_done_busy", BUSY, 0);
      chk("sat_done_wrq", MEM_WRQ, 0);
      drain();
      // push every other cycle past two pointer wraps
      for (int i = 0; i < 20; i++) begin
         push(24'hC00000 + 24'(i), 16'hC000 + 16'(i), i[0], 1'b1);
         chk("wrap_count_a", 32'(dut.count <= 1), 1);
         tick();
         chk("wrap_count_b", 32'(dut.count <= 1), 1);
      end
      drain();
      // reset during an issue with three entries queued
      MEM_RDY = 1'b0;
      for (int i = 0; i < 4; i++) push(24'hD00000 + 24'(i), 16'hD000, 1'b0, 1'b0);
      chk("pre_rst_wrq", MEM_WRQ, 1);
      chk("pre_rst_busy", BUSY, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_wrq", MEM_WRQ, 0);
      chk("async_rst_busy", BUSY, 0);
      @(posedge clkin);
      #3;
      reset = 1'b0;
      MEM_RDY = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("post_rst_wrq", MEM_WRQ, 0);
         chk("post_rst_busy", BUSY, 0);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ctx_wrq_fifo.md
CTX_WRQ_FIFO -- requirements
Module: ctx_wrq_fifo

Interface
REQ-001 Parameter DEPTH, default 8, number of buffered write entries; power of two, 2..32.
REQ-002 clkin  input  1  system clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 CTX_WRQ  input  1  single-cycle write request pulse from the context-capture stage.
REQ-005 CTX_ADDR  input  24  write address, valid when CTX_WRQ=1.
REQ-006 CTX_DATA  input  16  write data, valid when CTX_WRQ=1.
REQ-007 CTX_WORD  input  1  1 = 16-bit write, 0 = 8-bit write of CTX_DATA[7:0].
REQ-008 FLUSH  input  1  synchronous clear of queued entries and overflow status.
REQ-009 MEM_WRQ  output  1  write request to the memory bus arbiter.
REQ-010 MEM_RDY  input  1  arbiter acceptance of the presented request.
REQ-011 MEM_ADDR  output  24  address of the presented request.
REQ-012 MEM_DATA  output  16  data of the presented request.
REQ-013 MEM_WORD  output  1  word flag of the presented request.
REQ-014 BUSY  output  1  1 when any entry is queued or in flight.
REQ-015 OVF  output  1  sticky flag: at least one request dropped.
REQ-016 OVF_CNT  output  8  count of dropped requests, saturating.

Function
REQ-017 FIFO push: CTX_WRQ=1 and count<DEPTH writes {CTX_ADDR,CTX_DATA,CTX_WORD} at write pointer; pointer +1 mod DEPTH; count +1.
REQ-018 Full: CTX_WRQ=1 with count==DEPTH drops the request even if a pop occurs same cycle; sets OVF; OVF_CNT +1, saturating at 255.
REQ-019 Count width log2(DEPTH)+1; pointers wrap modulo DEPTH with no lost or duplicated entry.
REQ-020 Output FSM states: IDLE, ISSUE.
REQ-021 IDLE with count>0: pop head into output registers (MEM_ADDR/DATA/WORD), read pointer +1, MEM_WRQ<=1, go ISSUE.
REQ-022 IDLE with count==0: MEM_WRQ stays 0; output registers hold last values.
REQ-023 ISSUE: MEM_WRQ, MEM_ADDR, MEM_DATA, MEM_WORD held stable until MEM_RDY sampled 1.
REQ-024 ISSUE with MEM_RDY=1: MEM_WRQ<=0, go IDLE; next pop no earlier than following edge (min 2 cycles per transfer).
REQ-025 MEM_RDY while IDLE is ignored.
REQ-026 Latency: CTX_WRQ sampled at edge N into empty FIFO, FSM IDLE -> MEM_WRQ=1 after edge N+1.
REQ-027 Simultaneous push and pop: count unchanged; both pointers advance.
REQ-028 Order preserved: entries issued strictly in push order.
REQ-029 FLUSH=1: pointers and count cleared, OVF=0, OVF_CNT=0; a CTX_WRQ in the same cycle is discarded; an in-flight ISSUE transaction completes normally.
REQ-030 FLUSH has priority over push, pop and overflow accounting in the same cycle.
REQ-031 BUSY = (count!=0) | (state==ISSUE), combinational.

Reset
REQ-032 reset=1 asynchronously forces state IDLE, pointers 0, count 0, MEM_WRQ=0, MEM_ADDR=0, MEM_DATA=0, MEM_WORD=0, OVF=0, OVF_CNT=0.
REQ-033 reset asserted mid-ISSUE aborts the transaction; MEM_WRQ=0 immediately; queued entries discarded.
REQ-034 FIFO storage contents need not be reset; no stale entry is ever issued after reset.

Verification
REQ-035 Single push ADDR=F50123 DATA=00AB WORD=0, MEM_RDY tied 1 -> MEM_WRQ high exactly 1 cycle, 2 cycles after push, MEM_ADDR=F50123, MEM_DATA=00AB.
REQ-036 MEM_RDY held 0, 10 pushes (DEPTH=8) -> first entry in flight, 8 queued, 1 dropped, OVF=1, OVF_CNT=1; release MEM_RDY -> 9 writes in push order.
REQ-037 300 pushes while MEM_RDY=0 -> OVF_CNT saturates at 255; FLUSH -> OVF=0, OVF_CNT=0, BUSY=1 until in-flight entry accepted.
REQ-038 Continuous push every other cycle with MEM_RDY=1 across >2*DEPTH entries -> pointer wrap, no loss, count never exceeds 1.
REQ-039 Reset asserted while MEM_WRQ=1 with 3 queued -> MEM_WRQ falls without clock edge; after release BUSY=0, no request issued.
REQ-040 Push coincident with FLUSH -> entry discarded, MEM_WRQ stays 0 thereafter.
